// File: rtl/memory_stage.sv
// Data-memory access stage: issues RV32I loads/stores over a req/gnt/rvalid bus,
// extends load data into valM and hands the result to writeback via valid/ready.
module memory_stage #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [2:0]        func3,
  input  logic [XLEN-1:0]   valE,
  input  logic [XLEN-1:0]   valB,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   valE_out,
  output logic [XLEN-1:0]   valM,
  output logic              fault,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  // state  | meaning
  // IDLE   | ready for a new instruction
  // REQ    | memory request driven, waiting for mem_gnt
  // WAIT_R | load granted, waiting for mem_rvalid
  // RESP   | result presented to writeback, waiting for out_ready

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t state, state_nxt;

  logic              is_load, is_store, is_mem, acc_fault, accept;
  logic [XLEN-1:0]   enc_wdata;
  logic [XLEN/8-1:0] enc_wstrb;
  logic              store_r;
  logic [2:0]        f3_r;
  logic [1:0]        off_r;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_data;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load || is_store;
  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid;
  assign mem_req  = (state == REQ);
  assign out_valid = (state == RESP);

  // illegal width codes first, then alignment by access size (func3[1:0])
  always_comb begin
    acc_fault = 1'b0;
    if (is_load && (func3 == 3'b011 || func3 == 3'b110 || func3 == 3'b111))
      acc_fault = 1'b1;
    else if (is_store && func3 >= 3'b011)
      acc_fault = 1'b1;
    else if (is_mem && func3[1:0] == 2'b01 && valE[0])
      acc_fault = 1'b1;
    else if (is_mem && func3[1:0] == 2'b10 && valE[1:0] != 2'b00)
      acc_fault = 1'b1;
  end

  always_comb begin
    enc_wdata = '0;
    enc_wstrb = '0;
    if (is_store) begin
      case (func3)
        3'b000: begin
          enc_wdata = {4{valB[7:0]}};
          enc_wstrb = 4'b0001 << valE[1:0];
        end
        3'b001: begin
          enc_wdata = {2{valB[15:0]}};
          enc_wstrb = 4'b0011 << valE[1:0];
        end
        3'b010: begin
          enc_wdata = valB;
          enc_wstrb = 4'b1111;
        end
        default: begin
          enc_wdata = '0;
          enc_wstrb = '0;
        end
      endcase
    end
  end

  always_comb begin
    ld_byte = mem_rdata[8*off_r +: 8];
    ld_half = off_r[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_r)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {24'b0, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data = {16'b0, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (!is_mem || acc_fault) state_nxt = RESP;
          else                      state_nxt = REQ;
        end
      end
      REQ:    if (mem_gnt)    state_nxt = store_r ? RESP : WAIT_R;
      WAIT_R: if (mem_rvalid) state_nxt = RESP;
      RESP:   if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valE_out  <= '0;
      valM      <= '0;
      fault     <= 1'b0;
      store_r   <= 1'b0;
      f3_r      <= '0;
      off_r     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else if (accept) begin
      valE_out <= valE;
      valM     <= '0;
      fault    <= is_mem && acc_fault;
      store_r  <= is_store;
      f3_r     <= func3;
      off_r    <= valE[1:0];
      // bus fields only carry a request that will actually be issued
      if (is_mem && !acc_fault) begin
        mem_we    <= is_store;
        mem_addr  <= {valE[XLEN-1:2], 2'b00};
        mem_wdata <= enc_wdata;
        mem_wstrb <= enc_wstrb;
      end else begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end
    end else if (state == WAIT_R && mem_rvalid) begin
      valM <= ld_data;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: reset, loads, stores, stalls, faults, pass-through.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [31:0] valE, valB;
  logic        out_valid, out_ready;
  logic [31:0] valE_out, valM;
  logic        fault;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  memory_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func3(func3), .valE(valE), .valB(valB),
    .out_valid(out_valid), .out_ready(out_ready),
    .valE_out(valE_out), .valM(valM), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // presents one instruction; returns at T+1 (1 ns after the accepting edge)
  task automatic issue(input logic [6:0] op, input logic [2:0] f3,
                       input logic [31:0] e, input logic [31:0] b);
    in_valid = 1'b1;
    opcode   = op;
    func3    = f3;
    valE     = e;
    valB     = b;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; opcode = '0; func3 = '0; valE = '0; valB = '0;
    out_ready = 1'b1; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tick(); tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_valM", valM, 0);
    chk("rst_wstrb", mem_wstrb, 0);
    rst = 1'b0;
    tick();

    // LB, byte 3 = 0x80 -> sign extended
    issue(OP_LOAD, 3'b000, 32'h0000_1003, 32'h0);
    chk("lb_req", mem_req, 1);
    chk("lb_addr", mem_addr, 32'h0000_1000);
    chk("lb_wstrb", mem_wstrb, 0);
    chk("lb_we", mem_we, 0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("lb_req_drop", mem_req, 0);
    chk("lb_ov_t2", out_valid, 0);
    mem_rvalid = 1'b1; mem_rdata = 32'h80FF_1234;
    tick();
    mem_rvalid = 1'b0;
    chk("lb_ov_t3", out_valid, 1);
    chk("lb_valM", valM, 32'hFFFF_FF80);
    chk("lb_fault", fault, 0);
    tick();
    chk("lb_idle", in_ready, 1);

    // LHU upper half
    issue(OP_LOAD, 3'b101, 32'h0000_1002, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hBEEF_0000;
    tick();
    mem_rvalid = 1'b0;
    chk("lhu_valM", valM, 32'h0000_BEEF);
    tick();

    // LH lower half, negative
    issue(OP_LOAD, 3'b001, 32'h0000_1000, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_8001;
    tick();
    mem_rvalid = 1'b0;
    chk("lh_valM", valM, 32'hFFFF_8001);
    tick();

    // SB lane replication
    issue(OP_STORE, 3'b000, 32'h0000_2001, 32'h1234_56AB);
    chk("sb_we", mem_we, 1);
    chk("sb_wdata", mem_wdata, 32'hABAB_ABAB);
    chk("sb_wstrb", mem_wstrb, 4'b0010);
    chk("sb_addr", mem_addr, 32'h0000_2000);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("sb_ov_t2", out_valid, 1);
    chk("sb_valM", valM, 0);
    tick();

    // SH upper half
    issue(OP_STORE, 3'b001, 32'h0000_2002, 32'hAAAA_5678);
    chk("sh_wdata", mem_wdata, 32'h5678_5678);
    chk("sh_wstrb", mem_wstrb, 4'b1100);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    tick();

    // SW with grant stall and writeback stall
    out_ready = 1'b0;
    issue(OP_STORE, 3'b010, 32'h0000_3000, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) begin
      chk("sw_req_stall", mem_req, 1);
      chk("sw_addr_stall", mem_addr, 32'h0000_3000);
      chk("sw_wdata_stall", mem_wdata, 32'hCAFE_F00D);
      chk("sw_wstrb_stall", mem_wstrb, 4'b1111);
      tick();
    end
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sw_ov_hold", out_valid, 1);
      chk("sw_in_ready_hold", in_ready, 0);
      chk("sw_vale_hold", valE_out, 32'h0000_3000);
      chk("sw_valM_hold", valM, 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("sw_release", in_ready, 1);
    chk("sw_ov_drop", out_valid, 0);

    // misaligned LW faults without touching the bus
    issue(OP_LOAD, 3'b010, 32'h0000_1002, 32'h0);
    chk("lw_mis_req", mem_req, 0);
    chk("lw_mis_ov", out_valid, 1);
    chk("lw_mis_fault", fault, 1);
    chk("lw_mis_valM", valM, 0);
    tick();

    // illegal store width
    issue(OP_STORE, 3'b011, 32'h0000_1000, 32'h0);
    chk("sd_fault", fault, 1);
    chk("sd_req", mem_req, 0);
    tick();

    // odd halfword load
    issue(OP_LOAD, 3'b101, 32'h0000_1001, 32'h0);
    chk("lhu_odd_fault", fault, 1);
    tick();

    // ALU pass-through
    issue(OP_ALU, 3'b000, 32'hDEAD_BEEF, 32'h0);
    chk("pt_ov", out_valid, 1);
    chk("pt_vale", valE_out, 32'hDEAD_BEEF);
    chk("pt_valM", valM, 0);
    chk("pt_fault", fault, 0);
    chk("pt_req", mem_req, 0);
    tick();

    // reset in the middle of REQ
    issue(OP_LOAD, 3'b010, 32'h0000_4000, 32'h0);
    chk("rr_req", mem_req, 1);
    #2 rst = 1'b1;
    #1;
    chk("rr_req_drop", mem_req, 0);
    chk("rr_in_ready", in_ready, 1);
    chk("rr_vale_clr", valE_out, 0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b0;
    chk("rr_ov_stray", out_valid, 0);
    chk("rr_idle", in_ready, 1);
    chk("rr_valM", valM, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Consumer of the execute stage's results. Takes the effective address valE, store data valB, opcode and func3.
- Performs the RV32I LOAD/STORE data-memory access over a request/grant/response bus.
- Aligns and sign- or zero-extends load data into valM and hands the result to writeback over a valid/ready handshake.
- Non-memory instructions pass through with valE forwarded.

Parameters:
- XLEN, 32, data/address width. Only 32 is supported; byte-lane logic assumes 4 lanes.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  execute result valid
- in_ready  output  1  stage can accept
- opcode  input  7  instruction opcode (opcodes package: LOAD, STORE, others)
- func3  input  3  width/sign code
- valE  input  XLEN  effective address or ALU result
- valB  input  XLEN  store data (rs2)
- out_valid  output  1  result valid to writeback
- out_ready  input  1  writeback accepts
- valE_out  output  XLEN  latched valE
- valM  output  XLEN  extended load data; 0 for non-loads
- fault  output  1  misaligned or illegal func3 memory op
- mem_req  output  1  memory request
- mem_we  output  1  1 = write
- mem_addr  output  XLEN  word address, valE with [1:0] forced to 0
- mem_wdata  output  XLEN  lane-replicated store data
- mem_wstrb  output  XLEN/8  byte enables
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data valid
- mem_rdata  input  XLEN  read word

Behaviour:
- Reset (async): state IDLE. in_ready=1. out_valid=0, mem_req=0, mem_we=0, fault=0. valM, valE_out, mem_addr, mem_wdata all 0. mem_wstrb=0.
- FSM states: IDLE, REQ, WAIT_R, RESP. in_ready=1 only in IDLE. One instruction in flight at a time.
- IDLE, in_valid=1: latch all inputs. The next state is:
  - RESP with fault=0, valM=0, for a non-memory opcode.
  - RESP with fault=1, valM=0 and no bus activity, for a memory op that is faulting.
  - REQ otherwise.
- Fault conditions:
  - LOAD func3 in {011,110,111}, or STORE func3 >= 011: fault.
  - LH/LHU/SH with valE[0]=1: fault.
  - LW/SW with valE[1:0]!=0: fault.
- REQ: mem_req=1. mem_we, mem_addr, mem_wdata and mem_wstrb are held stable until mem_gnt. Waiting for mem_gnt is unbounded.
  - On gnt, a STORE goes to RESP.
  - On gnt, a LOAD goes to WAIT_R.
  - mem_req deasserts the cycle after gnt.
- WAIT_R: on mem_rvalid, capture mem_rdata, extract using the latched func3 and off=valE[1:0], then go to RESP. rvalid is valid no earlier than the cycle after gnt. rvalid arriving in any other state is ignored.
- Load extraction:
  - LB: sign-extend byte[off].
  - LBU: zero-extend byte[off].
  - LH: sign-extend half[off[1]].
  - LHU: zero-extend half[off[1]].
  - LW: full word.
- Store encoding:
  - SB: wdata = valB[7:0] replicated x4, wstrb = 0001<<off.
  - SH: wdata = valB[15:0] replicated x2, wstrb = 0011<<off.
  - SW: wdata = valB, wstrb = 1111.
  - For loads, wstrb = 0000 and we = 0.
- RESP: out_valid=1. valM, valE_out and fault are held stable until out_ready. On out_valid&&out_ready, go to IDLE; in_ready rises the following cycle.
- Latency (zero-wait memory, out_ready=1), from the accept cycle T:
  - pass-through: out_valid at T+1
  - store: gnt at T+1, out_valid at T+2
  - load: gnt at T+1, rvalid at T+2, out_valid at T+3
- Reset mid-transaction: the FSM returns to IDLE immediately and mem_req drops combinationally with the state. A late rvalid or gnt after reset is ignored. No output retains pre-reset data.
- valM is recomputed only on rvalid capture or at accept (cleared). It never changes while out_valid=1.

Test Plan:
- Reset mid-REQ: assert rst during REQ -> mem_req=0 the same cycle; state IDLE with in_ready=1 after release; a subsequent stray mem_rvalid=1 leaves out_valid=0.
- LB sign extension: LB valE=0x1003, mem_rdata=0x80FF_1234 -> mem_addr=0x1000, wstrb=0000, valM=0xFFFF_FF80, out_valid at T+3.
- LHU zero extension: LHU valE=0x1002, rdata=0xBEEF_0000 -> valM=0x0000_BEEF.
- SB lane replication: SB valE=0x2001, valB=0x1234_56AB -> mem_we=1, wdata=0xABAB_ABAB, wstrb=0010, out_valid at T+2, valM=0.
- Stall stability: SW valE=0x3000, mem_gnt low for 5 cycles -> req/addr/wdata/wstrb=1111 stable throughout; out_ready low for 3 cycles in RESP -> outputs stable, in_ready=0.
- Faults and pass-through: LW valE=0x1002 -> fault=1, mem_req never asserted. OP opcode valE=0xDEAD_BEEF -> out_valid at T+1, valE_out=0xDEAD_BEEF, valM=0, fault=0.
